// File: rtl/branch_target_buffer_pkg.sv
// Shared constants, FSM encoding and counter type for the branch target buffer.
// BTB_TWO_BIT_COUNTER_EN selects 2-bit saturating history; otherwise 1-bit last-outcome.
package branch_target_buffer_pkg;
    localparam int WORD_SIZE = 16;

    localparam logic [1:0] BTB_SRC_BR   = 2'd0;
    localparam logic [1:0] BTB_SRC_JR   = 2'd1;
    localparam logic [1:0] BTB_SRC_JMP  = 2'd2;
    localparam logic [1:0] BTB_SRC_NEXT = 2'd3;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } btb_state_e;

`ifdef BTB_TWO_BIT_COUNTER_EN
    localparam int         CTR_W     = 2;
    localparam logic [1:0] CTR_ALLOC = 2'b10;
    localparam logic [1:0] CTR_SWEEP = 2'b01;
`else
    localparam int         CTR_W     = 1;
    localparam logic [0:0] CTR_ALLOC = 1'b1;
    localparam logic [0:0] CTR_SWEEP = 1'b0;
`endif

    typedef logic [CTR_W-1:0] ctr_t;
endpackage

// File: rtl/btb_counter_update.sv
// Next-state function for the per-entry history counter (width set by BTB_TWO_BIT_COUNTER_EN).
// Saturates at both ends; with a 1-bit counter this degenerates to "remember last outcome".
module btb_counter_update (
    input  branch_target_buffer_pkg::ctr_t ctr,
    input  logic                           taken,
    output branch_target_buffer_pkg::ctr_t ctr_next
);
    import branch_target_buffer_pkg::*;

    always_comb begin
        ctr_next = ctr;
        if (taken && (ctr != '1))
            ctr_next = ctr + 1'b1;
        else if (!taken && (ctr != '0))
            ctr_next = ctr - 1'b1;
    end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational IF-side lookup, ID-side update, post-reset invalidate sweep.
// Counter width follows BTB_TWO_BIT_COUNTER_EN (see package).
module branch_target_buffer #(
    parameter int WORD_SIZE  = branch_target_buffer_pkg::WORD_SIZE,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = WORD_SIZE - INDEX_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] predicted_pc,
    output logic                 btb_hit,
    output logic                 busy,
    input  logic                 upd_valid,
    input  logic                 upd_advance,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic [1:0]           btb_src,
    input  logic [WORD_SIZE-1:0] br_target,
    input  logic [WORD_SIZE-1:0] jr_target,
    input  logic [WORD_SIZE-1:0] jump_addr,
    input  logic [WORD_SIZE-1:0] next_pc
);
    import branch_target_buffer_pkg::*;

    localparam int ENTRIES = 1 << INDEX_BITS;

    // Table storage has no reset; the sweep is what makes it safe to read.
    logic [ENTRIES-1:0]                valid_q;
    logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q;
    logic [ENTRIES-1:0][WORD_SIZE-1:0] target_q;
    logic [ENTRIES-1:0][CTR_W-1:0]     ctr_q;

    btb_state_e            state_q, state_d;
    logic [INDEX_BITS-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        if (state_q == INIT) begin
            busy  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1)
                state_d = RUN;
        end
    end

    // IF-side lookup; gated by RUN so never-swept entries are never consulted
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [WORD_SIZE-1:0]  pc_plus1;

    assign idx      = pc[INDEX_BITS-1:0];
    assign pc_tag   = pc[WORD_SIZE-1:INDEX_BITS];
    assign pc_plus1 = pc + 1'b1;
    assign btb_hit  = (state_q == RUN) && valid_q[idx] && (tag_q[idx] == pc_tag);

    always_comb begin
        predicted_pc = pc_plus1;
        if (btb_hit && ctr_q[idx][CTR_W-1])
            predicted_pc = target_q[idx];
    end

    // ID-side update
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  upd_en, upd_hit;
    logic [WORD_SIZE-1:0]  sel_target;
    ctr_t                  ctr_next;

    assign upd_idx = upd_pc[INDEX_BITS-1:0];
    assign upd_tag = upd_pc[WORD_SIZE-1:INDEX_BITS];
    assign upd_en  = upd_valid && upd_advance && (state_q == RUN);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        sel_target = br_target;
        case (btb_src)
            BTB_SRC_BR:   sel_target = br_target;
            BTB_SRC_JR:   sel_target = jr_target;
            BTB_SRC_JMP:  sel_target = jump_addr;
            BTB_SRC_NEXT: sel_target = next_pc;
            default:      sel_target = br_target;
        endcase
    end

    btb_counter_update u_ctr_upd (
        .ctr      (ctr_q[upd_idx]),
        .taken    (upd_taken),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            valid_q[cnt_q] <= 1'b0;
            ctr_q[cnt_q]   <= CTR_SWEEP;
        end else if (upd_en) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_next;
                if (upd_taken)
                    target_q[upd_idx] <= sel_target;
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= sel_target;
                ctr_q[upd_idx]    <= CTR_ALLOC;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus randomized
// traffic compared against an array-based reference model of the BTB rules.
module tb_branch_target_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc, predicted_pc, upd_pc;
    logic [15:0] br_target, jr_target, jump_addr, next_pc;
    logic        btb_hit, busy, upd_valid, upd_advance, upd_taken;
    logic [1:0]  btb_src;

    always #5 clk = ~clk;

    branch_target_buffer dut (
        .clk(clk), .reset(reset), .pc(pc), .predicted_pc(predicted_pc),
        .btb_hit(btb_hit), .busy(busy), .upd_valid(upd_valid),
        .upd_advance(upd_advance), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .btb_src(btb_src), .br_target(br_target), .jr_target(jr_target),
        .jump_addr(jump_addr), .next_pc(next_pc)
    );

`ifdef BTB_TWO_BIT_COUNTER_EN
    localparam int CMAX = 3;
`else
    localparam int CMAX = 1;
`endif

    // Reference model: 16 entries, plus remaining busy cycles
    bit mv   [16];
    int mtag [16];
    int mtgt [16];
    int mctr [16];
    int m_sweep;

    int vectors    = 0;
    int miscompares = 0;

    function automatic bit exp_hit(int p);
        if (m_sweep > 0) return 1'b0;
        return mv[p % 16] && (mtag[p % 16] == p / 16);
    endfunction

    function automatic int exp_pred(int p);
        if (exp_hit(p) && mctr[p % 16] > CMAX / 2) return mtgt[p % 16];
        return (p + 1) % 65536;
    endfunction

    function automatic void model_update();
        int i, t, tgt;
        i = int'(upd_pc) % 16;
        t = int'(upd_pc) / 16;
        case (btb_src)
            2'd0: tgt = int'(br_target);
            2'd1: tgt = int'(jr_target);
            2'd2: tgt = int'(jump_addr);
            default: tgt = int'(next_pc);
        endcase
        if (mv[i] && mtag[i] == t) begin
            if (upd_taken) begin
                mtgt[i] = tgt;
                if (mctr[i] < CMAX) mctr[i]++;
            end else if (mctr[i] > 0) begin
                mctr[i]--;
            end
        end else if (upd_taken) begin
            mv[i] = 1'b1; mtag[i] = t; mtgt[i] = tgt; mctr[i] = (CMAX + 1) / 2;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        m_sweep = 16;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (m_sweep > 0) m_sweep--;
            else if (upd_valid && upd_advance) model_update();
        end
        @(negedge clk);
    endtask

    task automatic set_upd(logic v, logic a, logic [15:0] p, logic t, logic [1:0] s);
        upd_valid = v; upd_advance = a; upd_pc = p; upd_taken = t; btb_src = s;
    endtask

    // Releases reset and counts busy cycles; a directed pc is checked on the first one.
    task automatic run_sweep(string name, logic drive_upd);
        int n;
        n = 0;
        reset = 1'b0;
        pc = 16'h0010;
        set_upd(drive_upd, drive_upd, 16'h0055, 1'b1, 2'd0);
        br_target = 16'h0777;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (busy !== 1'b1) break;
            if (n == 0) begin
                vectors++;
                if (predicted_pc !== 16'h0011 || btb_hit !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s_sweep_lookup: pred=%h hit=%b, need pred=0011 hit=0", name, predicted_pc, btb_hit);
                end
            end
            n++;
            tick();
        end
        set_upd(1'b0, 1'b0, 16'h0, 1'b0, 2'd0);
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL %s_busy_len: busy for %0d cycles, need 16", name, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pc = 16'h1234;
        #1;
        vectors++;
        if (busy !== 1'b1 || btb_hit !== 1'b0 || predicted_pc !== 16'h1235) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b hit=%b pred=%h, need 1 0 1235", busy, btb_hit, predicted_pc);
        end
        model_reset();
        tick(); tick();
        run_sweep("reset", 1'b1);
        // Updates offered during the sweep must have been dropped
        pc = 16'h0055;
        #1;
        vectors++;
        if (btb_hit !== 1'b0 || predicted_pc !== 16'h0056) begin
            miscompares++;
            $display("FAIL init_drop: hit=%b pred=%h, need 0 0056", btb_hit, predicted_pc);
        end
    endtask

    task automatic test_alloc();
        set_upd(1'b1, 1'b1, 16'h0023, 1'b1, 2'd0);
        br_target = 16'h0040;
        tick();
        set_upd(1'b0, 1'b0, 16'h0, 1'b0, 2'd0);
        pc = 16'h0023;
        #1;
        vectors++;
        if (btb_hit !== 1'b1 || predicted_pc !== 16'h0040) begin
            miscompares++;
            $display("FAIL alloc: hit=%b pred=%h, need 1 0040", btb_hit, predicted_pc);
        end
    endtask

    task automatic test_not_taken();
        for (int k = 0; k < 2; k++) begin
            set_upd(1'b1, 1'b1, 16'h0023, 1'b0, 2'd0);
            tick();
            set_upd(1'b0, 1'b0, 16'h0, 1'b0, 2'd0);
            pc = 16'h0023;
            #1;
            vectors++;
            if (btb_hit !== 1'b1 || predicted_pc !== 16'h0024) begin
                miscompares++;
                $display("FAIL not_taken_%0d: hit=%b pred=%h, need 1 0024", k, btb_hit, predicted_pc);
            end
        end
    endtask

    task automatic test_alias();
        set_upd(1'b1, 1'b1, 16'h0023, 1'b1, 2'd0);
        br_target = 16'h0040;
        tick();
        set_upd(1'b1, 1'b1, 16'h0033, 1'b1, 2'd2);
        jump_addr = 16'h0100;
        tick();
        set_upd(1'b0, 1'b0, 16'h0, 1'b0, 2'd0);
        pc = 16'h0023;
        #1;
        vectors++;
        if (btb_hit !== 1'b0 || predicted_pc !== 16'h0024) begin
            miscompares++;
            $display("FAIL alias_evicted: hit=%b pred=%h, need 0 0024", btb_hit, predicted_pc);
        end
        pc = 16'h0033;
        #1;
        vectors++;
        if (btb_hit !== 1'b1 || predicted_pc !== 16'h0100) begin
            miscompares++;
            $display("FAIL alias_winner: hit=%b pred=%h, need 1 0100", btb_hit, predicted_pc);
        end
    endtask

    task automatic test_no_advance();
        set_upd(1'b1, 1'b0, 16'h0058, 1'b1, 2'd1);
        jr_target = 16'h0abc;
        tick();
        set_upd(1'b0, 1'b1, 16'h0058, 1'b1, 2'd1);
        tick();
        set_upd(1'b0, 1'b0, 16'h0, 1'b0, 2'd0);
        pc = 16'h0058;
        #1;
        vectors++;
        if (btb_hit !== 1'b0 || predicted_pc !== 16'h0059) begin
            miscompares++;
            $display("FAIL no_advance: hit=%b pred=%h, need 0 0059", btb_hit, predicted_pc);
        end
    endtask

    task automatic test_random();
        int p;
        for (int c = 0; c < 400; c++) begin
            p = ($urandom_range(0, 9) == 0) ? 16'hFFFF : (($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
            pc = 16'(p);
            upd_valid   = ($urandom_range(0, 1) == 1);
            upd_advance = ($urandom_range(0, 3) != 0);
            upd_taken   = ($urandom_range(0, 4) < 3);
            upd_pc      = 16'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
            btb_src     = 2'($urandom_range(0, 3));
            br_target   = 16'($urandom);
            jr_target   = 16'($urandom);
            jump_addr   = 16'($urandom);
            next_pc     = 16'($urandom);
            #1;
            vectors++;
            if (btb_hit !== exp_hit(p) || predicted_pc !== 16'(exp_pred(p)) || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL random_%0d pc=%h: hit=%b pred=%h busy=%b, need hit=%b pred=%h busy=0",
                         c, pc, btb_hit, predicted_pc, busy, exp_hit(p), 16'(exp_pred(p)));
            end
            tick();
        end
        set_upd(1'b0, 1'b0, 16'h0, 1'b0, 2'd0);
    endtask

    task automatic test_reset_mid_run();
        set_upd(1'b1, 1'b1, 16'h0023, 1'b1, 2'd0);
        br_target = 16'h0040;
        tick();
        set_upd(1'b0, 1'b0, 16'h0, 1'b0, 2'd0);
        #2;
        reset = 1'b1;
        pc = 16'h0023;
        #1;
        vectors++;
        if (busy !== 1'b1 || btb_hit !== 1'b0 || predicted_pc !== 16'h0024) begin
            miscompares++;
            $display("FAIL mid_run_reset: busy=%b hit=%b pred=%h, need 1 0 0024", busy, btb_hit, predicted_pc);
        end
        model_reset();
        @(negedge clk);
        tick();
        run_sweep("mid_run", 1'b0);
        for (int k = 0; k < 3; k++) begin
            pc = (k == 0) ? 16'h0023 : (k == 1) ? 16'h0033 : 16'h0011;
            #1;
            vectors++;
            if (btb_hit !== 1'b0 || predicted_pc !== pc + 16'h1) begin
                miscompares++;
                $display("FAIL post_reset_miss pc=%h: hit=%b pred=%h, need 0 %h", pc, btb_hit, predicted_pc, pc + 16'h1);
            end
        end
        pc = 16'hFFFF;
        #1;
        vectors++;
        if (btb_hit !== 1'b0 || predicted_pc !== 16'h0000) begin
            miscompares++;
            $display("FAIL pc_wrap: hit=%b pred=%h, need 0 0000", btb_hit, predicted_pc);
        end
    endtask

    initial begin
        reset = 1'b1;
        pc = 16'h0;
        set_upd(1'b0, 1'b0, 16'h0, 1'b0, 2'd0);
        br_target = 16'h0; jr_target = 16'h0; jump_addr = 16'h0; next_pc = 16'h0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_alloc();
        test_not_taken();
        test_alias();
        test_no_advance();
        test_random();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
